lmsm_sequencer: RTL and testbench

LMSM_SEQUENCER -- requirements
Module: lmsm_sequencer

---
 rtl/lmsm_sequencer_if.sv | 35 +++
 rtl/lmsm_sequencer.sv | 102 ++++++++++
 tb/tb_lmsm_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/lmsm_sequencer_if.sv
// +----------------------------------------------------------------------+
// | lmsm_sequencer_if : start/memory/register-file bundle for the LM/SM   |
// | sequencer.                                          Revision: 1.0     |
// +----------------------------------------------------------------------+
`default_nettype none

interface lmsm_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic              is_store;
  logic [7:0]        imm8;
  logic [ADDR_W-1:0] base_addr;
  logic              mem_ready;
  logic [2:0]        reg_idx;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic              rf_wr_en;
  logic              stall;
  logic              done;
  logic [3:0]        xfer_cnt;

  modport master (
    output start, is_store, imm8, base_addr, mem_ready,
    input  reg_idx, mem_addr, mem_rd_en, mem_wr_en, rf_wr_en, stall, done, xfer_cnt
  );

  modport slave (
    input  start, is_store, imm8, base_addr, mem_ready,
    output reg_idx, mem_addr, mem_rd_en, mem_wr_en, rf_wr_en, stall, done, xfer_cnt
  );
endinterface

`default_nettype wire

// File: rtl/lmsm_sequencer.sv
// +----------------------------------------------------------------------+
// | lmsm_sequencer : walks an 8-bit register mask, issuing one memory     |
// | access per set bit for load/store-multiple.         Revision: 1.0     |
// +----------------------------------------------------------------------+
`default_nettype none

module lmsm_sequencer #(
  parameter int ADDR_W   = 16,
  parameter int ADDR_INC = 1
) (
  input  wire logic        clk,
  input  wire logic        reset,
  lmsm_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] c_addr_inc = ADDR_W'(ADDR_INC);

  state_t            r_state;
  state_t            w_state_next;
  logic [7:0]        r_mask;
  logic [ADDR_W-1:0] r_addr;
  logic              r_op;
  logic [3:0]        r_cnt;
  logic [2:0]        w_idx;
  logic [7:0]        w_mask_next;

  // Lowest set bit wins; the loop runs high-to-low so bit 0 is assigned last.
  always_comb begin
    w_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (r_mask[i]) w_idx = 3'(i);
    end
  end

  assign w_mask_next = r_mask & (r_mask - 8'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_mask  <= 8'd0;
      r_addr  <= '0;
      r_op    <= 1'b0;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && bus.start) begin
        r_cnt <= 4'd0;
        if (bus.imm8 != 8'd0) begin
          r_mask <= bus.imm8;
          r_addr <= bus.base_addr;
          r_op   <= bus.is_store;
        end
      end else if (r_state == S_XFER && bus.mem_ready) begin
        r_mask <= w_mask_next;
        r_addr <= r_addr + c_addr_inc;
        r_cnt  <= r_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    w_state_next  = r_state;
    bus.reg_idx   = 3'd0;
    bus.mem_addr  = '0;
    bus.mem_rd_en = 1'b0;
    bus.mem_wr_en = 1'b0;
    bus.rf_wr_en  = 1'b0;
    bus.done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_next = (bus.imm8 != 8'd0) ? S_XFER : S_DONE;
      end
      S_XFER: begin
        bus.reg_idx   = w_idx;
        bus.mem_addr  = r_addr;
        bus.mem_rd_en = !r_op;
        bus.mem_wr_en = r_op;
        if (bus.mem_ready) begin
          bus.rf_wr_en = !r_op;
          if (w_mask_next == 8'd0) w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        bus.done     = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign bus.stall    = (r_state != S_IDLE);
  assign bus.xfer_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_lmsm_sequencer.sv
// Self-checking bench for lmsm_sequencer: directed cases plus random LM/SM
// operations compared against a set-bit-list model.
`default_nettype none

module tb_lmsm_sequencer;

  localparam int ADDR_W   = 16;
  localparam int ADDR_INC = 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  lmsm_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  lmsm_sequencer #(.ADDR_W(ADDR_W), .ADDR_INC(ADDR_INC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic chk_quiet(input string tag, input logic [3:0] cnt, input logic stall_exp);
    chk({tag, "_rd"},    32'(bus.mem_rd_en), 32'd0);
    chk({tag, "_wr"},    32'(bus.mem_wr_en), 32'd0);
    chk({tag, "_rfwr"},  32'(bus.rf_wr_en),  32'd0);
    chk({tag, "_idx"},   32'(bus.reg_idx),   32'd0);
    chk({tag, "_addr"},  32'(bus.mem_addr),  32'd0);
    chk({tag, "_stall"}, 32'(bus.stall),     32'(stall_exp));
    chk({tag, "_cnt"},   32'(bus.xfer_cnt),  32'(cnt));
  endtask

  // One LM/SM operation. The expected sequence is the ascending list of set
  // mask bits; the k-th transfer uses address base + k*ADDR_INC.
  // lo_first forces mem_ready low on the first XFER cycles, then ready
  // follows ready_pct.
  task automatic run_op(input logic op, input logic [7:0] m, input logic [15:0] base,
                        input int ready_pct, input int lo_first, input bit noisy_start);
    int         q[$];
    int         k;
    int         cyc;
    logic       rdy;
    logic [15:0] ea;
    for (int i = 0; i < 8; i++) if (m[i]) q.push_back(i);

    @(negedge clk);
    bus.start = 1'b1; bus.is_store = op; bus.imm8 = m; bus.base_addr = base;
    bus.mem_ready = 1'b1;
    #1;
    chk("idle_stall", 32'(bus.stall), 32'd0);
    chk("idle_done",  32'(bus.done),  32'd0);

    k = 0; cyc = 0;
    while (k < q.size()) begin
      @(negedge clk);
      bus.start     = noisy_start ? 1'($urandom) : 1'b0;
      bus.is_store  = 1'($urandom);
      bus.imm8      = 8'($urandom);
      bus.base_addr = 16'($urandom);
      rdy = (cyc < lo_first) ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
      bus.mem_ready = rdy;
      #1;
      ea = base + 16'(k * ADDR_INC);
      chk("x_idx",   32'(bus.reg_idx),   32'(q[k]));
      chk("x_addr",  32'(bus.mem_addr),  32'(ea));
      chk("x_rd",    32'(bus.mem_rd_en), 32'(!op));
      chk("x_wr",    32'(bus.mem_wr_en), 32'(op));
      chk("x_rfwr",  32'(bus.rf_wr_en),  32'(!op && rdy));
      chk("x_stall", 32'(bus.stall),     32'd1);
      chk("x_done",  32'(bus.done),      32'd0);
      chk("x_cnt",   32'(bus.xfer_cnt),  32'(k));
      if (rdy) k++;
      cyc++;
      if (cyc > 400) begin
        chk("x_timeout", 32'(cyc), 32'd400);
        break;
      end
    end

    @(negedge clk);
    bus.start = 1'($urandom); bus.imm8 = 8'($urandom) | 8'h01; bus.mem_ready = 1'($urandom);
    #1;
    chk("d_done", 32'(bus.done), 32'd1);
    chk_quiet("d", 4'(q.size()), 1'b1);

    @(negedge clk);
    bus.start = 1'b0; bus.mem_ready = 1'b0;
    #1;
    chk("i_done", 32'(bus.done), 32'd0);
    chk_quiet("i", 4'(q.size()), 1'b0);
  endtask

  initial begin
    bus.start = 1'b0; bus.is_store = 1'b0; bus.imm8 = 8'd0;
    bus.base_addr = '0; bus.mem_ready = 1'b0;

    // Reset state, with inputs active to show they are ignored.
    #12;
    bus.start = 1'b1; bus.imm8 = 8'hFF; bus.mem_ready = 1'b1;
    #10;
    chk("rst_done", 32'(bus.done), 32'd0);
    chk_quiet("rst", 4'd0, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    reset = 1'b1;

    // Directed cases.
    run_op(1'b0, 8'b1000_0101, 16'h0040, 100, 0, 1'b0);
    run_op(1'b1, 8'hFF,        16'hFFFE, 100, 0, 1'b0);
    run_op(1'b0, 8'b0001_0000, 16'h1234, 100, 3, 1'b0);
    run_op(1'b1, 8'h00,        16'h5555, 100, 0, 1'b0);

    // Reset mid-SM: abort, outputs drop immediately, no done pulse.
    @(negedge clk);
    bus.start = 1'b1; bus.is_store = 1'b1; bus.imm8 = 8'h0F; bus.base_addr = 16'h0200;
    bus.mem_ready = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    #1;
    chk("ab_idx", 32'(bus.reg_idx), 32'd1);
    @(negedge clk);
    #1;
    chk("ab_idx2", 32'(bus.reg_idx), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    chk("ab_done", 32'(bus.done), 32'd0);
    chk_quiet("ab", 4'd0, 1'b0);
    @(negedge clk);
    #1;
    chk("ab_done2", 32'(bus.done), 32'd0);
    reset = 1'b1;
    run_op(1'b0, 8'h01, 16'h0300, 100, 0, 1'b0);

    // Random operations with random mem_ready and stray start pulses.
    for (int n = 0; n < 30; n++) begin
      run_op(1'($urandom), 8'($urandom), 16'($urandom),
             $urandom_range(20, 100), $urandom_range(0, 2), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
